decoder_scan_nbit: RTL and testbench

//   Parametrised, registered SEL_W-to-2**SEL_W one-hot decoder with a DIRECT mode and a SCAN mode.

---
 rtl/decoder_scan_nbit_pkg.sv | 11 +
 rtl/decoder_scan_nbit_onehot_decoder.sv | 21 ++
 rtl/decoder_scan_nbit.sv | 112 +++++++++++
 tb/tb_decoder_scan_nbit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/decoder_scan_nbit_pkg.sv
// Shared encodings for the registered one-hot decoder with direct and scan modes.
package decoder_scan_nbit_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_nbit_onehot_decoder.sv
// Combinational SEL_W-to-2**SEL_W active-high one-hot decode.
module onehot_decoder #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [(1<<SEL_W)-1:0] onehot
);

    // Compare the select against every line index
    always_comb begin
        onehot = '0;
        for (int i = 0; i < (1 << SEL_W); i++) begin
            if (sel == SEL_W'(i)) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/decoder_scan_nbit.sv
// Registered one-hot line decoder: direct decode of a qualified select, or an
// autonomous walking one-hot scan with a programmable dwell per line.
module decoder_scan_nbit
    import decoder_scan_nbit_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    input  logic [SEL_W-1:0]      in_lines,
    output logic [(1<<SEL_W)-1:0] out_lines,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  wrap
);

    localparam int               N_LINES   = 1 << SEL_W;
    localparam int               CNT_W     = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = {SEL_W{1'b1}};
    localparam logic             POL       = (ACTIVE_LOW != 0);
    localparam logic [N_LINES-1:0] INACTIVE = {N_LINES{POL}};

    logic [1:0]         state_r;
    logic [1:0]         next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   next_cnt_s;
    logic [SEL_W-1:0]   next_sel_s;
    logic               next_valid_s;
    logic               next_wrap_s;
    logic [N_LINES-1:0] onehot_s;

    // State selection depends only on en/mode, so an illegal state code self-heals
    always_comb begin
        next_state_s = ST_IDLE;
        if (!en) begin
            next_state_s = ST_IDLE;
        end else if (mode == MODE_SCAN) begin
            next_state_s = ST_SCAN;
        end else begin
            next_state_s = ST_DIRECT;
        end
    end

    // Next-cycle select, valid, wrap and dwell count for the target state
    always_comb begin
        next_sel_s   = cur_sel;
        next_valid_s = 1'b0;
        next_wrap_s  = 1'b0;
        next_cnt_s   = '0;
        case (next_state_s)
            ST_DIRECT: begin
                if (in_valid) begin
                    next_sel_s   = in_lines;
                    next_valid_s = 1'b1;
                end else if (state_r == ST_DIRECT) begin
                    next_valid_s = out_valid;
                end else begin
                    next_valid_s = 1'b0;
                end
            end
            ST_SCAN: begin
                next_valid_s = 1'b1;
                if (state_r != ST_SCAN) begin
                    next_sel_s = '0;
                end else if (cnt_r == CNT_LAST) begin
                    next_sel_s  = cur_sel + SEL_W'(1);
                    next_wrap_s = (cur_sel == SEL_LAST);
                end else begin
                    next_cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                next_valid_s = 1'b0;
            end
        endcase
    end

    onehot_decoder #(.SEL_W(SEL_W)) u_onehot (
        .sel    (next_sel_s),
        .onehot (onehot_s)
    );

    // Output and state registers; polarity is applied here so the decoder stays active-high
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            cur_sel   <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            out_lines <= INACTIVE;
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= next_cnt_s;
            cur_sel   <= next_sel_s;
            out_valid <= next_valid_s;
            wrap      <= next_wrap_s;
            if (next_valid_s) begin
                out_lines <= onehot_s ^ INACTIVE;
            end else begin
                out_lines <= INACTIVE;
            end
        end
    end

endmodule

// File: tb/tb_decoder_scan_nbit.sv
// Directed bench: default-polarity DWELL=2 instance plus an ACTIVE_LOW, DWELL=1 instance.
module tb_decoder_scan_nbit;

    logic       clk = 1'b0;
    logic       rst, en, mode, in_valid;
    logic [2:0] in_lines;
    logic       rst2, en2, mode2;

    logic [7:0] out_lines, out_lines2;
    logic       out_valid, out_valid2, wrap, wrap2;
    logic [2:0] cur_sel, cur_sel2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decoder_scan_nbit #(.SEL_W(3), .DWELL(2), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
        .in_lines(in_lines), .out_lines(out_lines), .out_valid(out_valid),
        .cur_sel(cur_sel), .wrap(wrap)
    );

    decoder_scan_nbit #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .in_valid(in_valid),
        .in_lines(in_lines), .out_lines(out_lines2), .out_valid(out_valid2),
        .cur_sel(cur_sel2), .wrap(wrap2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_l;
        rst = 1'b1; en = 1'b1; mode = 1'b1; in_valid = 1'b0; in_lines = 3'd0;
        rst2 = 1'b1; en2 = 1'b1; mode2 = 1'b1;

        // Reset dominates an active scan request
        tick(); tick();
        chk("rst_lines", {24'd0, out_lines}, 32'h00);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sel",   {29'd0, cur_sel},   32'd0);
        chk("rst_wrap",  {31'd0, wrap},      32'd0);

        // Direct decode sweep, one-cycle latency
        rst = 1'b0; mode = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_lines = 3'(i);
            tick();
            exp_l = 8'd1 << i;
            chk("dir_lines", {24'd0, out_lines}, {24'd0, exp_l});
            chk("dir_valid", {31'd0, out_valid}, 32'd1);
            chk("dir_sel",   {29'd0, cur_sel},   32'(i));
        end
        in_valid = 1'b0; in_lines = 3'd2;
        tick(); tick();
        chk("dir_hold",       {24'd0, out_lines}, 32'h80);
        chk("dir_hold_valid", {31'd0, out_valid}, 32'd1);

        // Idle: outputs inactive, select held
        en = 1'b0;
        tick();
        chk("idle_lines", {24'd0, out_lines}, 32'h00);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_sel",   {29'd0, cur_sel},   32'd7);

        // Scan from idle: two cycles per line, wrap on return to line 0
        en = 1'b1; mode = 1'b1; in_valid = 1'b1; in_lines = 3'd6;
        for (int k = 0; k <= 17; k++) begin
            tick();
            exp_l = 8'd1 << ((k / 2) % 8);
            chk("scan_lines", {24'd0, out_lines}, {24'd0, exp_l});
            chk("scan_wrap",  {31'd0, wrap},      (k == 16) ? 32'd1 : 32'd0);
        end

        // One idle cycle mid-scan restarts with a full dwell
        en = 1'b0;
        tick();
        chk("pause_lines", {24'd0, out_lines}, 32'h00);
        chk("pause_valid", {31'd0, out_valid}, 32'd0);
        en = 1'b1;
        tick();
        chk("restart_0", {24'd0, out_lines}, 32'h01);
        tick();
        chk("restart_1", {24'd0, out_lines}, 32'h01);
        tick();
        chk("restart_2", {24'd0, out_lines}, 32'h02);

        // Scan to direct with a capture on the switching edge
        mode = 1'b0; in_valid = 1'b1; in_lines = 3'd5;
        tick();
        chk("sw_lines", {24'd0, out_lines}, 32'h20);
        chk("sw_wrap",  {31'd0, wrap},      32'd0);
        chk("sw_sel",   {29'd0, cur_sel},   32'd5);

        // Entering direct without a qualifier shows nothing until the first capture
        en = 1'b0;
        tick();
        en = 1'b1; in_valid = 1'b0;
        tick();
        chk("dir_entry_lines", {24'd0, out_lines}, 32'h00);
        chk("dir_entry_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1; in_lines = 3'd3;
        tick();
        chk("dir_first_cap", {24'd0, out_lines}, 32'h08);

        // Active-low, single-cycle dwell instance
        rst2 = 1'b0;
        tick();
        chk("al_step0", {24'd0, out_lines2}, 32'hFE);
        tick();
        chk("al_step1", {24'd0, out_lines2}, 32'hFD);
        tick();
        chk("al_step2", {24'd0, out_lines2}, 32'hFB);
        rst2 = 1'b1;
        tick();
        chk("al_rst_lines", {24'd0, out_lines2}, 32'hFF);
        chk("al_rst_valid", {31'd0, out_valid2}, 32'd0);
        rst2 = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            tick();
            exp_l = ~(8'd1 << (k % 8));
            chk("al_walk",      {24'd0, out_lines2}, {24'd0, exp_l});
            chk("al_walk_wrap", {31'd0, wrap2},      (k == 8) ? 32'd1 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
